// File: rtl/display_pkg.sv
// Shared constants for the result display: digit geometry, data widths and
// the active-low seven-segment glyphs in g..a bit order.
package display_pkg;

    localparam int unsigned NUM_DIGITS  = 8;
    localparam int unsigned DIGIT_IDX_W = 3;
    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned SEG_W       = 7;
    localparam int unsigned RESULT_W    = 32;
    localparam int unsigned COUNT_W     = 16;
    localparam int unsigned HIST_SEL_W  = 2;
    localparam int unsigned HIST_DEPTH  = 4;

    // Active-low glyphs, bit 6 = g ... bit 0 = a
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/result_display_driver_if.sv
// Capture bus from the processor core to the display driver.
//   processor_result  : result word to capture
//   update_display_en : single-cycle capture strobe
//   hist_sel          : history depth select (0 = latest)
interface result_display_driver_if;
    import display_pkg::*;

    logic [RESULT_W-1:0]   processor_result;
    logic                  update_display_en;
    logic [HIST_SEL_W-1:0] hist_sel;

    modport master (output processor_result, update_display_en, hist_sel);
    modport slave  (input  processor_result, update_display_en, hist_sel);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph decoder.
//   nibble : 4-bit hex value
//   seg_c  : glyph, g..a order, active-low
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
        endcase
    end

endmodule

// File: rtl/result_display_driver.sv
// Captures processor result words and scans them onto an 8-digit
// multiplexed seven-segment display (hex, digit 0 = least significant nibble).
//   clk, rst      : clock; asynchronous active-low reset
//   bus           : capture bus (result_display_driver_if.slave)
//   seg, dp, an   : registered segment / decimal point / digit enables, active-low
//   result_valid  : a result has been captured since reset
//   capture_count : captures since reset, wrapping 16-bit
// Build option: define DISPLAY_HISTORY_EN to keep the last four captures and
// select among them with hist_sel; otherwise a single capture register is kept.
module result_display_driver
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    result_display_driver_if.slave    bus,
    output logic [SEG_W-1:0]          seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      result_valid,
    output logic [COUNT_W-1:0]        capture_count
);

    localparam int unsigned PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PRESC_W-1:0]     presc;
    logic [DIGIT_IDX_W-1:0] digit_idx;
    logic                   presc_tc_c;
    logic [RESULT_W-1:0]    sel_value_c;
    logic                   sel_valid_c;
    logic [NIBBLE_W-1:0]    nibble_c;
    logic [SEG_W-1:0]       glyph_c;

    assign presc_tc_c = (presc == PRESC_W'(REFRESH_DIV - 1));

    // Refresh prescaler and digit scan index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            digit_idx <= '0;
        end else if (presc_tc_c) begin
            presc     <= '0;
            digit_idx <= digit_idx + DIGIT_IDX_W'(1);
        end else begin
            presc     <= presc + PRESC_W'(1);
        end
    end

    // Capture status, common to both storage variants
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_valid  <= 1'b0;
            capture_count <= '0;
        end else if (bus.update_display_en) begin
            result_valid  <= 1'b1;
            capture_count <= capture_count + COUNT_W'(1);
        end
    end

`ifdef DISPLAY_HISTORY_EN
    logic [RESULT_W-1:0]   hist_mem [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_vld;
    logic [HIST_SEL_W-1:0] wr_ptr;
    logic [HIST_SEL_W-1:0] rd_ptr_c;

    // Ring of the most recent captures; wr_ptr points at the oldest slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_mem <= '{default: '0};
            hist_vld <= '0;
            wr_ptr   <= '0;
        end else if (bus.update_display_en) begin
            hist_mem[wr_ptr] <= bus.processor_result;
            hist_vld[wr_ptr] <= 1'b1;
            wr_ptr           <= wr_ptr + HIST_SEL_W'(1);
        end
    end

    // k-th most recent entry sits k+1 slots behind the write pointer
    always_comb begin
        rd_ptr_c    = wr_ptr - HIST_SEL_W'(1) - bus.hist_sel;
        sel_value_c = hist_mem[rd_ptr_c];
        sel_valid_c = hist_vld[rd_ptr_c];
    end
`else
    logic [RESULT_W-1:0] cap_value;
    logic                unused_hist_sel;

    assign unused_hist_sel = ^bus.hist_sel;

    // Single capture register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_value <= '0;
        end else if (bus.update_display_en) begin
            cap_value <= bus.processor_result;
        end
    end

    always_comb begin
        sel_value_c = cap_value;
        sel_valid_c = result_valid;
    end
`endif

    assign nibble_c = sel_value_c[{digit_idx, 2'b00} +: NIBBLE_W];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_c),
        .seg_c  (glyph_c)
    );

    // Registered display outputs; dark while in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= sel_valid_c ? glyph_c : SEG_DASH;
            an  <= ~(NUM_DIGITS'(1) << digit_idx);
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_display_driver.sv
// Randomized self-checking bench for result_display_driver (REFRESH_DIV = 4).
// A behavioural model tracks edges since reset release and the list of
// captured words; expected digit/segment values are derived arithmetically.
module tb_result_display_driver;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        result_valid;
    logic [15:0] capture_count;

    int n_tests = 0;
    int n_fail  = 0;

    result_display_driver_if bus ();

    result_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .seg           (seg),
        .dp            (dp),
        .an            (an),
        .result_valid  (result_valid),
        .capture_count (capture_count)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          k;          // rising edges since reset release
    logic [31:0] m_q[$];     // last (up to) four captures, newest at the back
    logic [31:0] m_prev_q[$];// captures as they stood before the latest edge
    int          m_count;
    logic [1:0]  m_sel_prev; // hist_sel seen at the latest edge

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            k = 0;
            m_q.delete();
            m_prev_q.delete();
            m_count = 0;
            m_sel_prev = 2'd0;
        end else begin
            k++;
            m_prev_q   = m_q;
            m_sel_prev = bus.hist_sel;
            if (bus.update_display_en) begin
                m_q.push_back(bus.processor_result);
                if (m_q.size() > 4) void'(m_q.pop_front());
                m_count = (m_count + 1) % 65536;
            end
        end
    end

    function automatic int exp_digit();
        return ((k - 1) / int'(DIV)) % 8;
    endfunction

    function automatic logic [7:0] exp_an();
        logic [7:0] a;
        a = 8'hFF;
        if (k > 0) a[exp_digit()] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_seg();
        int          sel;
        logic [31:0] v;
        int          nib;
        if (k == 0) return 7'h7F;
`ifdef DISPLAY_HISTORY_EN
        sel = int'(m_sel_prev);
`else
        sel = 0;
`endif
        if (m_prev_q.size() <= sel) return 7'h3F;
        v   = m_prev_q[m_prev_q.size() - 1 - sel];
        nib = int'((v >> (4 * exp_digit())) & 32'hF);
        return glyph[nib];
    endfunction

    // Cycle-by-cycle comparison against the model
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en && rst) begin
            check_eq("an",    32'(an),            32'(exp_an()));
            check_eq("seg",   32'(seg),           32'(exp_seg()));
            check_eq("dp",    32'(dp),            32'd1);
            check_eq("valid", 32'(result_valid),  32'(m_q.size() > 0));
            check_eq("count", 32'(capture_count), 32'(m_count));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic strobe(input logic [31:0] v);
        bus.processor_result  = v;
        bus.update_display_en = 1'b1;
        @(negedge clk);
        bus.update_display_en = 1'b0;
    endtask

    // Watch one full scan and compare what each digit showed
    task automatic sweep_expect(input string tag, input logic [31:0] val, input bit dashes);
        logic [6:0] seen [8];
        bit         hit  [8];
        logic [3:0] nib;
        for (int d = 0; d < 8; d++) begin
            seen[d] = 7'h7F;
            hit[d]  = 1'b0;
        end
        for (int c = 0; c < int'(8 * DIV + 2); c++) begin
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                if (an == ~(8'd1 << d)) begin
                    seen[d] = seg;
                    hit[d]  = 1'b1;
                end
            end
        end
        for (int d = 0; d < 8; d++) begin
            nib = val[4*d +: 4];
            check_eq({tag, "_scanned"}, 32'(hit[d]), 32'd1);
            check_eq(tag, 32'(seen[d]), dashes ? 32'h3F : 32'(glyph[nib]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          kb;
        int          cb;
        int          dn;
        logic [31:0] v;
        logic [7:0]  ea;

        rst = 1'b0;
        bus.processor_result  = '0;
        bus.update_display_en = 1'b0;
        bus.hist_sel          = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_an",    32'(an),            32'hFF);
        check_eq("rst_seg",   32'(seg),           32'h7F);
        check_eq("rst_dp",    32'(dp),            32'd1);
        check_eq("rst_valid", 32'(result_valid),  32'd0);
        check_eq("rst_count", 32'(capture_count), 32'd0);

        // Idle after release: dashes everywhere
        rst    = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check_eq("first_an", 32'(an), 32'hFE);
        sweep_expect("idle_dash", 32'h0, 1'b1);
        check_eq("idle_valid", 32'(result_valid),  32'd0);
        check_eq("idle_count", 32'(capture_count), 32'd0);

        // Single capture
        strobe(32'h1234ABCD);
        check_eq("cap_valid", 32'(result_valid),  32'd1);
        check_eq("cap_count", 32'(capture_count), 32'd1);
        sweep_expect("cap_digits", 32'h1234ABCD, 1'b0);

        // Strobe on the prescaler terminal cycle
        for (int i = 0; i < int'(DIV) && (k % int'(DIV)) != int'(DIV) - 1; i++) @(negedge clk);
        kb = k;
        cb = int'(capture_count);
        v  = 32'hCAFEF00D;
        strobe(v);
        check_eq("coin_count", 32'(capture_count), 32'((cb + 1) % 65536));
        @(negedge clk);
        dn = ((kb + 1) / int'(DIV)) % 8;
        ea = ~(8'd1 << dn);
        check_eq("coin_an",  32'(an),  32'(ea));
        check_eq("coin_seg", 32'(seg), 32'(glyph[4'((v >> (4 * dn)) & 32'hF)]));

        // Strobe held for five cycles: five captures, last one shown
        cb = int'(capture_count);
        bus.update_display_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.processor_result = 32'h5A5A0000 + 32'(i);
            @(negedge clk);
        end
        bus.update_display_en = 1'b0;
        check_eq("hold_count", 32'(capture_count), 32'((cb + 5) % 65536));
        sweep_expect("hold_digits", 32'h5A5A0004, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            bus.update_display_en = ($urandom_range(3) == 0);
            bus.processor_result  = $urandom;
            bus.hist_sel          = 2'($urandom_range(3));
            @(negedge clk);
        end
        bus.update_display_en = 1'b0;
        bus.hist_sel          = '0;

`ifdef DISPLAY_HISTORY_EN
        do_reset();
        strobe(32'h1);
        strobe(32'h2);
        strobe(32'h3);
        bus.hist_sel = 2'd2;
        sweep_expect("hist_sel2", 32'h00000001, 1'b0);
        bus.hist_sel = 2'd3;
        sweep_expect("hist_sel3", 32'h0, 1'b1);
        bus.hist_sel = 2'd0;
        sweep_expect("hist_sel0", 32'h00000003, 1'b0);
`endif

        // 65536 captures wrap the counter back to zero
        chk_en = 1'b0;
        do_reset();
        bus.update_display_en = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.processor_result = 32'(i);
            @(negedge clk);
        end
        bus.update_display_en = 1'b0;
        check_eq("wrap_count", 32'(capture_count), 32'd0);
        check_eq("wrap_valid", 32'(result_valid),  32'd1);
        chk_en = 1'b1;
        sweep_expect("wrap_digits", 32'h0000FFFF, 1'b0);

        // Reset mid-scan darkens the display immediately
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_an",    32'(an),            32'hFF);
        check_eq("midrst_seg",   32'(seg),           32'h7F);
        check_eq("midrst_valid", 32'(result_valid),  32'd0);
        check_eq("midrst_count", 32'(capture_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("resume_an", 32'(an), 32'hFE);
        sweep_expect("resume_dash", 32'h0, 1'b1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_display_driver.md
RESULT_DISPLAY_DRIVER -- requirements
Module: result_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (minimum 2).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port processor_result  input  32  result word from the processor core.
REQ-005 SHALL have port update_display_en  input  1  single-cycle capture strobe from the processor core.
REQ-006 SHALL have port hist_sel  input  2  history depth select (0 = latest); used only when DISPLAY_HISTORY_EN is defined.
REQ-007 SHALL have port seg  output  7  segments a..g, active-low.
REQ-008 SHALL have port dp  output  1  decimal point, active-low; driven 1 at all times.
REQ-009 SHALL have port an  output  8  digit enables, active-low, one-hot.
REQ-010 SHALL have port result_valid  output  1  high once at least one result has been captured since reset.
REQ-011 SHALL have port capture_count  output  16  number of captures since reset, wraps from 0xFFFF to 0x0000.

Function
REQ-012 SHALL capture processor_result on any rising clk edge where update_display_en=1; the displayed value SHALL reflect the capture from the following cycle.
REQ-013 SHALL increment capture_count and set result_valid on the same edge as each capture.
REQ-014 SHALL run a prescaler counting 0..REFRESH_DIV-1 that wraps to 0; at terminal count, the 3-bit digit index SHALL advance, wrapping 7->0.
REQ-015 SHALL drive an[i]=0 only for i equal to the digit index, with every other bit of an at 1.
REQ-016 SHALL show hex nibble value[4i+3:4i] on digit i using the standard 0-F glyphs (e.g. 0 -> seg=7'b1000000, 8 -> 7'b0000000, in g..a order).
REQ-017 SHALL show a dash (only segment g lit, seg=7'b0111111) on every digit while the selected entry is invalid.
REQ-018 SHALL perform both operations independently when a capture and a prescaler terminal count coincide, with no lost capture and no lost step.
REQ-019 SHALL keep update_display_en held high for N cycles equivalent to N captures, with the last one displayed.
REQ-020 SHALL register seg and an so they are glitch-free, with one cycle of latency from the digit index and the value.

Reset
REQ-021 SHALL, on asserting rst=0, immediately clear: prescaler=0, digit index=0, captured value(s)=0, result_valid=0, capture_count=0, and all valid flags=0.
REQ-022 SHALL, while in reset, drive an=8'hFF, seg=7'h7F and dp=1 (display dark).
REQ-023 SHALL discard any capture in flight when rst is asserted mid-operation, and SHALL resume scanning from digit 0 on the first edge after release.

Configuration
REQ-024 SHALL, when macro DISPLAY_HISTORY_EN is defined, keep a 4-entry ring of the last four captures with per-entry valid flags; hist_sel=k SHALL select the k-th most recent capture.
REQ-025 SHALL show dashes when DISPLAY_HISTORY_EN is defined and hist_sel selects an entry not yet written since reset.
REQ-026 SHALL, when DISPLAY_HISTORY_EN is undefined, hold a single capture register and ignore hist_sel; result_valid and capture_count behaviour SHALL be unchanged.

Structure
REQ-027 SHALL place the seven-segment glyph constants (0-F, dash, blank) and the digit-count constant 8 in shared package display_pkg.
REQ-028 SHALL implement nibble-to-segment decoding in one combinational sub-module, hex_to_seg7.

Verification
REQ-029 SHALL verify reset behaviour: after reset release with no strobe, all 8 scanned digits show a dash, result_valid=0 and capture_count=0.
REQ-030 SHALL verify single capture: strobe with 0x1234ABCD -> digits 0..7 show D,C,B,A,4,3,2,1; result_valid=1; capture_count=1.
REQ-031 SHALL verify scan timing: with REFRESH_DIV=4, an steps FE,FD,FB,...,7F,FE with each value held exactly 4 cycles.
REQ-032 SHALL verify coincident events: a strobe on the prescaler terminal cycle -> new value captured and the digit index advances on the same edge.
REQ-033 SHALL verify history (DISPLAY_HISTORY_EN defined): capture 0x1,0x2,0x3, then hist_sel=2 shows 00000001, and hist_sel=3 shows dashes.
REQ-034 SHALL verify wrap and reset: 65536 strobes -> capture_count=0; rst=0 mid-scan -> an=FF immediately.
